// File: rtl/store_narrow_pkg.sv
// Shared constants for store_narrow: size encodings, FSM state codes and
// datapath helpers.
package store_narrow_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_MERGE = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    function automatic logic [DATA_W-1:0] word_addr(input logic [DATA_W-1:0] a);
        return {a[DATA_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/store_narrow_lane_merge.sv
// lane_merge: inserts the narrow store value into its lane of the read word
// and flags values that do not fit the store width.
module lane_merge
    import store_narrow_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic [31:0] wr_data,
    input  logic [31:0] rd_data,
    input  logic        ori_signal,
    output logic [31:0] merged,
    output logic        trunc
);

    always_comb begin
        merged = rd_data;
        trunc  = 1'b0;
        case (size)
            SZ_BYTE: begin
                case (lane)
                    2'd0: merged[7:0]   = wr_data[7:0];
                    2'd1: merged[15:8]  = wr_data[7:0];
                    2'd2: merged[23:16] = wr_data[7:0];
                    2'd3: merged[31:24] = wr_data[7:0];
                    default: merged = rd_data;
                endcase
                trunc = ori_signal ? (wr_data[31:8] != '0)
                                   : (wr_data[31:8] != {24{wr_data[7]}});
            end
            SZ_HALF: begin
                if (lane[1])
                    merged[31:16] = wr_data[15:0];
                else
                    merged[15:0]  = wr_data[15:0];
                trunc = ori_signal ? (wr_data[31:16] != '0)
                                   : (wr_data[31:16] != {16{wr_data[15]}});
            end
            SZ_WORD: merged = wr_data;
            default: merged = rd_data;
        endcase
    end

endmodule

// File: rtl/store_narrow.sv
// store_narrow: read-modify-write FSM for byte/halfword/word stores.
// Optional misalignment trap enabled by defining STORE_ALIGN_CHECK_EN.
module store_narrow
    import store_narrow_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Start,
    input  logic [1:0]  Size,
    input  logic [31:0] Addr,
    input  logic [31:0] WrData,
    input  logic        OriSignal,
    output logic [31:0] MemAddr,
    output logic        MemRdEn,
    input  logic [31:0] MemRdData,
    output logic        MemWrEn,
    output logic [31:0] MemWrData,
    output logic        Busy,
    output logic        Done,
    output logic        Trunc,
    output logic        AlignErr
);

    logic [2:0]  state;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic [31:0] data_q;
    logic        ori_q;
    logic [31:0] merged;
    logic        trunc_c;
    logic        misalign;
    logic        accept;

    assign accept = (state == ST_IDLE) && Start;

`ifdef STORE_ALIGN_CHECK_EN
    always_comb begin
        misalign = ((Size == SZ_HALF) && Addr[0]) ||
                   ((Size == SZ_WORD) && (Addr[1:0] != 2'b00));
    end

    // Set at acceptance; a misaligned request enters DONE on that same edge.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            AlignErr <= 1'b0;
        else if (accept)
            AlignErr <= misalign;
    end
`else
    assign misalign = 1'b0;
    assign AlignErr = 1'b0;
`endif

    lane_merge u_lane_merge (
        .size       (size_q),
        .lane       (lane_q),
        .wr_data    (data_q),
        .rd_data    (MemRdData),
        .ori_signal (ori_q),
        .merged     (merged),
        .trunc      (trunc_c)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= ST_IDLE;
            size_q    <= '0;
            lane_q    <= '0;
            data_q    <= '0;
            ori_q     <= 1'b0;
            MemAddr   <= '0;
            MemRdEn   <= 1'b0;
            MemWrEn   <= 1'b0;
            MemWrData <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Trunc     <= 1'b0;
        end else begin
            MemRdEn <= 1'b0;
            MemWrEn <= 1'b0;
            Done    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        size_q  <= Size;
                        lane_q  <= Addr[1:0];
                        data_q  <= WrData;
                        ori_q   <= OriSignal;
                        MemAddr <= word_addr(Addr);
                        Trunc   <= 1'b0;
                        Busy    <= 1'b1;
                        if ((Size == SZ_RSVD) || misalign) begin
                            state <= ST_DONE;
                            Done  <= 1'b1;
                        end else if (Size == SZ_WORD) begin
                            state     <= ST_WRITE;
                            MemWrEn   <= 1'b1;
                            MemWrData <= WrData;
                        end else begin
                            state   <= ST_READ;
                            MemRdEn <= 1'b1;
                        end
                    end
                end
                ST_READ: state <= ST_MERGE;
                ST_MERGE: begin
                    // Memory data arrives one cycle after MemRdEn.
                    state     <= ST_WRITE;
                    MemWrEn   <= 1'b1;
                    MemWrData <= merged;
                end
                ST_WRITE: begin
                    state <= ST_DONE;
                    Done  <= 1'b1;
                    Trunc <= trunc_c;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    Busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_narrow.sv
// Directed self-checking bench for store_narrow with a one-cycle-latency
// memory model.
module tb_store_narrow;

    logic        Clk;
    logic        Rst_n;
    logic        Start;
    logic [1:0]  Size;
    logic [31:0] Addr;
    logic [31:0] WrData;
    logic        OriSignal;
    logic [31:0] MemAddr;
    logic        MemRdEn;
    logic [31:0] MemRdData;
    logic        MemWrEn;
    logic [31:0] MemWrData;
    logic        Busy;
    logic        Done;
    logic        Trunc;
    logic        AlignErr;

    int unsigned n_cmp;
    int unsigned n_bad;

    logic [31:0] mem_word;
    int unsigned rd_cnt;
    int unsigned wr_cnt;
    int unsigned both_cnt;
    logic [31:0] wr_seen;
    logic [31:0] addr_seen;

    store_narrow dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Start     (Start),
        .Size      (Size),
        .Addr      (Addr),
        .WrData    (WrData),
        .OriSignal (OriSignal),
        .MemAddr   (MemAddr),
        .MemRdEn   (MemRdEn),
        .MemRdData (MemRdData),
        .MemWrEn   (MemWrEn),
        .MemWrData (MemWrData),
        .Busy      (Busy),
        .Done      (Done),
        .Trunc     (Trunc),
        .AlignErr  (AlignErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Read data is only valid in the cycle after MemRdEn; garbage otherwise.
    always @(posedge Clk) begin
        MemRdData <= MemRdEn ? mem_word : 32'h5A5A_A5A5;
    end

    always @(negedge Clk) begin
        if (MemRdEn) begin
            rd_cnt    = rd_cnt + 1;
            addr_seen = MemAddr;
        end
        if (MemWrEn) begin
            wr_cnt    = wr_cnt + 1;
            wr_seen   = MemWrData;
            addr_seen = MemAddr;
        end
        if (MemRdEn && MemWrEn)
            both_cnt = both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Caller is at a negedge. Issues one store, optionally re-asserts Start
    // while busy, then checks latency, memory traffic and status flags.
    task automatic run_op(input string tag, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] d, input logic ori, input logic [31:0] rdw,
                          input logic [31:0] exp_wr, input logic exp_trunc,
                          input int unsigned exp_lat, input int unsigned exp_rd,
                          input int unsigned exp_wr_cnt, input logic [31:0] exp_addr,
                          input logic exp_align, input logic hold_start);
        int unsigned lat;
        mem_word  = rdw;
        Size      = sz;
        Addr      = a;
        WrData    = d;
        OriSignal = ori;
        Start     = 1'b1;
        @(posedge Clk);
        #1;
        rd_cnt    = 0;
        wr_cnt    = 0;
        both_cnt  = 0;
        Start     = hold_start;
        Size      = ~sz;
        Addr      = ~a;
        WrData    = ~d;
        OriSignal = ~ori;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge Clk);
            if (i == 2) Start = 1'b0;
            if (Done) begin
                lat = i;
                break;
            end
        end
        check({tag, ".lat"},   lat, exp_lat);
        check({tag, ".busy"},  {31'd0, Busy}, 32'd1);
        check({tag, ".trunc"}, {31'd0, Trunc}, {31'd0, exp_trunc});
        check({tag, ".align"}, {31'd0, AlignErr}, {31'd0, exp_align});
        check({tag, ".rdcnt"}, rd_cnt, exp_rd);
        check({tag, ".wrcnt"}, wr_cnt, exp_wr_cnt);
        check({tag, ".both"},  both_cnt, 0);
        if (exp_wr_cnt != 0) begin
            check({tag, ".wrdata"}, wr_seen, exp_wr);
            check({tag, ".addr"},   addr_seen, exp_addr);
        end
        Start = 1'b0;
        @(negedge Clk);
        check({tag, ".done_pulse"}, {31'd0, Done}, 32'd0);
        check({tag, ".idle"},       {31'd0, Busy}, 32'd0);
        check({tag, ".trunc_hold"}, {31'd0, Trunc}, {31'd0, exp_trunc});
        @(negedge Clk);
        check({tag, ".no_restart"}, {31'd0, Busy}, 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rd_cnt = 0;
        wr_cnt = 0;
        both_cnt = 0;
        wr_seen = '0;
        addr_seen = '0;
        mem_word = '0;
        Rst_n = 1'b0;
        Start = 1'b0;
        Size = 2'b00;
        Addr = '0;
        WrData = '0;
        OriSignal = 1'b0;

        #1;
        check("reset.outs", {MemRdEn, MemWrEn, Busy, Done, Trunc, AlignErr}, 6'd0);
        check("reset.addr", MemAddr, 32'h0);
        check("reset.wdata", MemWrData, 32'h0);

        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        // Start presented immediately: must be taken on the first edge out of reset.
        run_op("byte_lane2", 2'b00, 32'h0000_0102, 32'h0000_007F, 1'b0, 32'hAABB_CCDD,
               32'hAA7F_CCDD, 1'b0, 4, 1, 1, 32'h0000_0100, 1'b0, 1'b0);

        @(negedge Clk);
        run_op("byte_s80", 2'b00, 32'h0000_0100, 32'h0000_0080, 1'b0, 32'h1122_3344,
               32'h1122_3380, 1'b1, 4, 1, 1, 32'h0000_0100, 1'b0, 1'b0);
        run_op("byte_u80", 2'b00, 32'h0000_0100, 32'h0000_0080, 1'b1, 32'h1122_3344,
               32'h1122_3380, 1'b0, 4, 1, 1, 32'h0000_0100, 1'b0, 1'b0);
        run_op("byte_lane3", 2'b00, 32'h0000_0107, 32'hFFFF_FF12, 1'b0, 32'h0000_0000,
               32'h1200_0000, 1'b1, 4, 1, 1, 32'h0000_0104, 1'b0, 1'b0);
        run_op("byte_neg_s", 2'b00, 32'h0000_0001, 32'hFFFF_FF80, 1'b0, 32'hFFFF_FFFF,
               32'hFFFF_80FF, 1'b0, 4, 1, 1, 32'h0000_0000, 1'b0, 1'b0);
        run_op("byte_neg_u", 2'b00, 32'h0000_0001, 32'hFFFF_FF80, 1'b1, 32'hFFFF_FFFF,
               32'hFFFF_80FF, 1'b1, 4, 1, 1, 32'h0000_0000, 1'b0, 1'b0);
        run_op("half_hi", 2'b01, 32'h0000_0202, 32'hFFFF_8001, 1'b0, 32'h1122_3344,
               32'h8001_3344, 1'b0, 4, 1, 1, 32'h0000_0200, 1'b0, 1'b0);
        run_op("half_lo_u", 2'b01, 32'h0000_0200, 32'h0001_2345, 1'b1, 32'h1122_3344,
               32'h1122_2345, 1'b1, 4, 1, 1, 32'h0000_0200, 1'b0, 1'b0);
        run_op("word", 2'b10, 32'h0000_0300, 32'hDEAD_BEEF, 1'b0, 32'h1234_5678,
               32'hDEAD_BEEF, 1'b0, 2, 0, 1, 32'h0000_0300, 1'b0, 1'b1);
        run_op("rsvd", 2'b11, 32'h0000_0400, 32'hFFFF_FFFF, 1'b0, 32'h1234_5678,
               32'h0, 1'b0, 1, 0, 0, 32'h0, 1'b0, 1'b0);
`ifdef STORE_ALIGN_CHECK_EN
        run_op("half_mis", 2'b01, 32'h0000_0101, 32'h0000_BEEF, 1'b1, 32'h1122_3344,
               32'h0, 1'b0, 1, 0, 0, 32'h0, 1'b1, 1'b0);
        run_op("word_mis", 2'b10, 32'h0000_0302, 32'hCAFE_F00D, 1'b0, 32'h1122_3344,
               32'h0, 1'b0, 1, 0, 0, 32'h0, 1'b1, 1'b0);
        run_op("half_ok", 2'b01, 32'h0000_0102, 32'h0000_0042, 1'b0, 32'h1122_3344,
               32'h0042_3344, 1'b0, 4, 1, 1, 32'h0000_0100, 1'b0, 1'b0);
`else
        run_op("half_mis", 2'b01, 32'h0000_0101, 32'h0000_BEEF, 1'b1, 32'h1122_3344,
               32'h1122_BEEF, 1'b0, 4, 1, 1, 32'h0000_0100, 1'b0, 1'b0);
        run_op("word_mis", 2'b10, 32'h0000_0302, 32'hCAFE_F00D, 1'b0, 32'h1122_3344,
               32'hCAFE_F00D, 1'b0, 2, 0, 1, 32'h0000_0300, 1'b0, 1'b0);
`endif

        // Reset asserted while in MERGE: the pending write must be dropped.
        mem_word  = 32'h1122_3344;
        Size      = 2'b00;
        Addr      = 32'h0000_0505;
        WrData    = 32'h0000_0080;
        OriSignal = 1'b0;
        Start     = 1'b1;
        @(posedge Clk);
        #1;
        Start  = 1'b0;
        rd_cnt = 0;
        wr_cnt = 0;
        repeat (2) @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        check("rst_mid.outs", {MemRdEn, MemWrEn, Busy, Done, Trunc, AlignErr}, 6'd0);
        check("rst_mid.addr", MemAddr, 32'h0);
        repeat (3) @(negedge Clk);
        check("rst_mid.wrcnt", wr_cnt, 0);
        check("rst_mid.rdcnt", rd_cnt, 1);
        Rst_n = 1'b1;
        run_op("after_rst", 2'b00, 32'h0000_0506, 32'h0000_0033, 1'b1, 32'h1122_3344,
               32'h1133_3344, 1'b0, 4, 1, 1, 32'h0000_0504, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
